rr_arbiter_8: RTL

- Eight-requester round-robin arbiter that grants exclusive access to one shared resource at a time.
- Selection uses a rotating-priority variant of the 8-to-3 priority encode, so no requester is starved.
- A grant is held until the owner signals done.
- Sits in front of any shared single-port datapath in the synthetic benchmark set.

---
 rtl/rr_arbiter_8.sv | 65 ++++++
 1 files changed

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with done-based release; optional forced release via ARB_TIMEOUT_EN
module rr_arbiter_8 #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t     state, state_n;
  logic [2:0] ptr, ptr_n, win, idx_n;
  logic [7:0] grant_n;
  logic       valid_n, expire;
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("rr_arbiter_8: TIMEOUT must be in 2..255");
  end
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign expire = (state == BUSY) && !done && (cnt == 8'(TIMEOUT - 1));
  // hold-time counter: zero while idle, counts busy cycles without done
  always_ff @(posedge clk) begin
    cnt     <= (rst || state == IDLE || expire) ? 8'd0 : done ? cnt : cnt + 8'd1;
    timeout <= rst ? 1'b0 : expire;
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif
  // rotating-priority pick plus next-state/output computation
  always_comb begin
    win = ptr;
    for (int i = 7; i >= 0; i--)
      if (req[ptr + 3'(i)]) win = ptr + 3'(i);
    state_n = state;
    ptr_n   = ptr;
    grant_n = grant;
    idx_n   = grant_idx;
    valid_n = grant_valid;
    if (state == IDLE && |req) begin
      state_n = BUSY;
      grant_n = 8'd1 << win;
      idx_n   = win;
      valid_n = 1'b1;
    end else if (state == BUSY && (done || expire)) begin
      state_n = IDLE;
      ptr_n   = grant_idx + 3'd1;
      grant_n = 8'd0;
      idx_n   = 3'd0;
      valid_n = 1'b0;
    end
  end
  // registered state and outputs
  always_ff @(posedge clk) begin
    state       <= rst ? IDLE : state_n;
    ptr         <= rst ? 3'd0 : ptr_n;
    grant       <= rst ? 8'd0 : grant_n;
    grant_idx   <= rst ? 3'd0 : idx_n;
    grant_valid <= rst ? 1'b0 : valid_n;
  end
endmodule
